ep_buf_arb: RTL and testbench
=============================

# ep_buf_arb

Parametrised N-channel arbiter for the USB core's shared endpoint-buffer port pair: the TX-buffer write port and the RX-buffer read port. It replaces a fixed two-way, select-driven mux. Round-robin grant with optional burst lock and optional preemption lets the CPU bus bridge, the external data interface and further DMA-style engines share one buffer. It sits between those masters and the `usb` instance's `ep_tx_*_0` / `ep_rx_*_0` ports.

## Interface
- `N_CH`, 2: number of requesting channels (2..8).
- `TX_AW`, 8: TX buffer word-address width.
- `RX_AW`, 9: RX buffer word-address width.
- `DW`, 16: buffer data width; mask width is `DW/8`.
- `MAX_HOLD`, 0: maximum cycles one owner keeps the grant while others request; 0 disables preemption.
- `clk` in 1: single clock.
- `rst` in 1: asynchronous, active-low reset.
- `ch_req` in N_CH: per-channel bus request (level).
- `ch_gnt` out N_CH: one-hot grant, registered.
- `ch_tx_addr` in N_CH*TX_AW: flattened, channel i at `[i*TX_AW +: TX_AW]`.
- `ch_tx_data` in N_CH*DW: flattened TX write data.
- `ch_tx_wmsk` in N_CH*DW/8: flattened write mask; 1 = byte NOT written.
- `ch_tx_we` in N_CH: TX write strobe.
- `ch_rx_addr` in N_CH*RX_AW: flattened RX read address.
- `ch_rx_re` in N_CH: RX read strobe.
- `ch_rx_data` out DW: RX read data, broadcast to all channels.
- `ch_rx_vld` out N_CH: read data valid for channel i.
- `ep_tx_addr_0` out TX_AW: to USB core.
- `ep_tx_data_0` out DW: to USB core.
- `ep_tx_wmsk_0` out DW/8: to USB core.
- `ep_tx_we_0` out 1: to USB core.
- `ep_rx_addr_0` out RX_AW: to USB core.
- `ep_rx_re_0` out 1: to USB core.
- `ep_rx_data_1` in DW: from USB core; 1-cycle read latency.
- `owner` out 3: index of the granted channel; valid while `busy`.
- `busy` out 1: some channel holds the grant.

## Operation
- Arbiter state: `owner` register, `busy` flag, round-robin pointer `last`, hold counter `hcnt` (width ceil(log2(MAX_HOLD+1)), min 1).
- Idle (`busy`=0): if any `ch_req` is set, grant the first requester scanning `last+1, last+2, …` modulo N_CH. Set `busy`, `owner`, `last`=owner, `hcnt`=0.
- Owned: the grant is kept while `ch_req[owner]`=1, unless preempted.
- Release: when `ch_req[owner]`=0, the grant moves directly to the next requester in round-robin order from `owner+1`. If there is none, go Idle. There are no idle cycles between owners.
- Preemption (MAX_HOLD>0):
  - `hcnt` increments each owned cycle only while another channel requests; it resets to 0 otherwise and on every grant change.
  - When `hcnt` = MAX_HOLD-1 and another channel requests, the grant moves to the next requester at the following edge, even if the owner still requests.
  - A preempted owner re-enters the round-robin normally.
- Qualification: only the granted channel's `tx_we`/`rx_re` reach the core. Strobes from non-granted channels are dropped silently; there is no queuing.
- TX path: `ep_tx_*_0` are registered from the granted channel's inputs. `ep_tx_we_0` = `tx_we[owner] & busy`. Address, data and mask are muxed from `owner` regardless of `we`.
- RX path: `ep_rx_addr_0` and `ep_rx_re_0` are combinational from the granted channel. `ep_rx_re_0` = `rx_re[owner] & busy`.
- Read return: a 1-cycle pipeline of (re accepted, owner) drives `ch_rx_vld`. `ch_rx_data` = `ep_rx_data_1`.

## Timing
- Reset (`rst`=0), asynchronous: `ch_gnt`=0, `busy`=0, `owner`=0, `last`=N_CH-1 (so channel 0 wins first), `hcnt`=0, `ep_tx_*_0`=0, `ch_rx_vld`=0. `ep_rx_re_0`=0 follows because `busy`=0.
- Request to grant: `ch_req[i]` sampled high at edge k gives `ch_gnt[i]`=1 after edge k.
- Grant switch: owner drops `req` in cycle k; the new grant is visible after edge k+1. No cycle has two grants.
- TX write: strobe in a cycle with the grant reaches `ep_tx_we_0` one cycle later (1 cycle latency).
- RX read: accepted `re` in cycle k gives `ch_rx_vld[owner_k]`=1 and valid data in cycle k+1. This holds even if the grant changed at edge k+1.
- Reset mid-operation: in-flight TX register and RX valid pipeline are cleared. A pending `ep_rx_data_1` is discarded.
- `ch_req` for an out-of-range index cannot exist. `owner` always < N_CH.

## Test plan
- N_CH=2, MAX_HOLD=0, only ch1 requests, writes addr 0x12 data 0xBEEF wmsk 2'b00: `ch_gnt`=2'b10 one cycle later; `ep_tx_we_0`=1, addr 0x12, data 0xBEEF one cycle after the strobe.
- N_CH=4, all request from reset, each drops `req` after 3 cycles then re-requests: grant order 0,1,2,3,0; no idle cycle between owners; exactly one `ch_gnt` bit per cycle.
- N_CH=2, MAX_HOLD=4, ch0 holds `req` continuously, ch1 requests at cycle 10: ch0 keeps the grant 4 counted cycles, then ch1 is granted; with both still requesting, ch0 regains it 4 cycles later.
- Non-granted ch1 pulses `tx_we` and `rx_re` while ch0 owns: `ep_tx_we_0` and `ep_rx_re_0` stay 0 for ch1's strobes; `ch_rx_vld[1]` stays 0.
- ch0 reads addr 0x1FF in its last owned cycle, model returns 0xA5A5: the next cycle shows `ch_rx_vld`=2'b01 and `ch_rx_data`=0xA5A5, while ch1 is already granted.
- Assert `rst`=0 mid-burst with `ep_tx_we_0`=1 pending: all outputs 0 immediately (asynchronous); after release, channel 0 has priority.

Source files
------------

// File: rtl/ep_buf_arb.sv
// Round-robin arbiter sharing the USB core's endpoint TX-write / RX-read buffer
// ports among N_CH masters, with optional hold-time preemption.

module ep_buf_arb_lane #(
  parameter int TX_AW = 8,
  parameter int RX_AW = 9,
  parameter int DW    = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               own,
  input  logic               busy,
  input  logic [TX_AW-1:0]   tx_addr,
  input  logic [DW-1:0]      tx_data,
  input  logic [DW/8-1:0]    tx_wmsk,
  input  logic               tx_we,
  input  logic [RX_AW-1:0]   rx_addr,
  input  logic               rx_re,
  output logic [TX_AW-1:0]   tx_addr_m,
  output logic [DW-1:0]      tx_data_m,
  output logic [DW/8-1:0]    tx_wmsk_m,
  output logic               tx_we_m,
  output logic [RX_AW-1:0]   rx_addr_m,
  output logic               rx_re_m,
  output logic               rx_vld
);
  // Fields are zeroed unless this lane owns the port, so the top can OR-reduce.
  assign tx_addr_m = own ? tx_addr : '0;
  assign tx_data_m = own ? tx_data : '0;
  assign tx_wmsk_m = own ? tx_wmsk : '0;
  assign rx_addr_m = own ? rx_addr : '0;
  assign tx_we_m   = own & busy & tx_we;
  assign rx_re_m   = own & busy & rx_re;

  always_ff @(posedge clk or negedge rst)
    if (!rst) rx_vld <= 1'b0;
    else      rx_vld <= rx_re_m;
endmodule

module ep_buf_arb #(
  parameter int N_CH     = 2,
  parameter int TX_AW    = 8,
  parameter int RX_AW    = 9,
  parameter int DW       = 16,
  parameter int MAX_HOLD = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_CH-1:0]         ch_req,
  output logic [N_CH-1:0]         ch_gnt,
  input  logic [N_CH*TX_AW-1:0]   ch_tx_addr,
  input  logic [N_CH*DW-1:0]      ch_tx_data,
  input  logic [N_CH*DW/8-1:0]    ch_tx_wmsk,
  input  logic [N_CH-1:0]         ch_tx_we,
  input  logic [N_CH*RX_AW-1:0]   ch_rx_addr,
  input  logic [N_CH-1:0]         ch_rx_re,
  output logic [DW-1:0]           ch_rx_data,
  output logic [N_CH-1:0]         ch_rx_vld,
  output logic [TX_AW-1:0]        ep_tx_addr_0,
  output logic [DW-1:0]           ep_tx_data_0,
  output logic [DW/8-1:0]         ep_tx_wmsk_0,
  output logic                    ep_tx_we_0,
  output logic [RX_AW-1:0]        ep_rx_addr_0,
  output logic                    ep_rx_re_0,
  input  logic [DW-1:0]           ep_rx_data_1,
  output logic [2:0]              owner,
  output logic                    busy
);
  localparam int MW = DW/8;
  localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD+1) : 1;
  localparam logic [HW-1:0] HLIM = HW'((MAX_HOLD > 0) ? MAX_HOLD-1 : 0);

  typedef struct packed {
    logic [TX_AW-1:0] addr;
    logic [DW-1:0]    data;
    logic [MW-1:0]    wmsk;
    logic             we;
  } tx_t;

  logic [2:0]      owner_q, owner_d, last_q, last_d;
  logic            busy_q, busy_d;
  logic [HW-1:0]   hcnt_q, hcnt_d;
  logic [N_CH-1:0] gnt_d, own_oh;
  logic            own_req, others;
  tx_t             tx_mux, tx_q;
  logic [RX_AW-1:0] rx_addr_mux;
  logic            rx_re_mux;

  logic [N_CH-1:0][TX_AW-1:0] l_tx_addr;
  logic [N_CH-1:0][DW-1:0]    l_tx_data;
  logic [N_CH-1:0][MW-1:0]    l_tx_wmsk;
  logic [N_CH-1:0][RX_AW-1:0] l_rx_addr;
  logic [N_CH-1:0]            l_tx_we, l_rx_re;

  // First requester at or after 'from' (mod N_CH).
  function automatic logic [2:0] rr_pick(input logic [N_CH-1:0] req, input int from);
    logic [2:0] r;
    int idx;
    r = '0;
    for (int k = N_CH-1; k >= 0; k--) begin
      idx = (from + k) % N_CH;
      if (req[idx]) r = 3'(idx);
    end
    return r;
  endfunction

  for (genvar i = 0; i < N_CH; i++) begin : g_lane
    assign own_oh[i] = (owner_q == 3'(i));
    assign gnt_d[i]  = busy_d && (owner_d == 3'(i));

    ep_buf_arb_lane #(.TX_AW(TX_AW), .RX_AW(RX_AW), .DW(DW)) u_lane (
      .clk       (clk),
      .rst       (rst),
      .own       (own_oh[i]),
      .busy      (busy_q),
      .tx_addr   (ch_tx_addr[i*TX_AW +: TX_AW]),
      .tx_data   (ch_tx_data[i*DW +: DW]),
      .tx_wmsk   (ch_tx_wmsk[i*MW +: MW]),
      .tx_we     (ch_tx_we[i]),
      .rx_addr   (ch_rx_addr[i*RX_AW +: RX_AW]),
      .rx_re     (ch_rx_re[i]),
      .tx_addr_m (l_tx_addr[i]),
      .tx_data_m (l_tx_data[i]),
      .tx_wmsk_m (l_tx_wmsk[i]),
      .tx_we_m   (l_tx_we[i]),
      .rx_addr_m (l_rx_addr[i]),
      .rx_re_m   (l_rx_re[i]),
      .rx_vld    (ch_rx_vld[i])
    );
  end

  assign own_req = |(ch_req & own_oh);
  assign others  = |(ch_req & ~own_oh);

  always_comb begin
    owner_d = owner_q;
    busy_d  = busy_q;
    last_d  = last_q;
    hcnt_d  = '0;
    if (!busy_q) begin
      if (|ch_req) begin
        busy_d  = 1'b1;
        owner_d = rr_pick(ch_req, int'(last_q) + 1);
        last_d  = owner_d;
      end
    end else if (!own_req || (MAX_HOLD > 0 && others && hcnt_q == HLIM)) begin
      // Hand over directly to the next requester; no idle gap between owners.
      if (others) begin
        owner_d = rr_pick(ch_req & ~own_oh, int'(owner_q) + 1);
        last_d  = owner_d;
      end else begin
        busy_d = 1'b0;
      end
    end else if (others && MAX_HOLD > 0) begin
      hcnt_d = hcnt_q + 1'b1;
    end
  end

  always_comb begin
    tx_mux      = '0;
    rx_addr_mux = '0;
    for (int i = 0; i < N_CH; i++) begin
      tx_mux.addr = tx_mux.addr | l_tx_addr[i];
      tx_mux.data = tx_mux.data | l_tx_data[i];
      tx_mux.wmsk = tx_mux.wmsk | l_tx_wmsk[i];
      rx_addr_mux = rx_addr_mux | l_rx_addr[i];
    end
    tx_mux.we = |l_tx_we;
    rx_re_mux = |l_rx_re;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_q <= '0;
      busy_q  <= 1'b0;
      last_q  <= 3'(N_CH-1);
      hcnt_q  <= '0;
      ch_gnt  <= '0;
      tx_q    <= '0;
    end else begin
      owner_q <= owner_d;
      busy_q  <= busy_d;
      last_q  <= last_d;
      hcnt_q  <= hcnt_d;
      ch_gnt  <= gnt_d;
      tx_q    <= tx_mux;
    end
  end

  assign owner        = owner_q;
  assign busy         = busy_q;
  assign ep_tx_addr_0 = tx_q.addr;
  assign ep_tx_data_0 = tx_q.data;
  assign ep_tx_wmsk_0 = tx_q.wmsk;
  assign ep_tx_we_0   = tx_q.we;
  assign ep_rx_addr_0 = rx_addr_mux;
  assign ep_rx_re_0   = rx_re_mux;
  assign ch_rx_data   = ep_rx_data_1;
endmodule

// File: tb/tb_ep_buf_arb.sv
// Directed bench: instance A (2 ch, hold limit 4) and instance B (4 ch, no preemption).

module tb_ep_buf_arb;
  logic clk, rst;
  int total, bad;

  logic [1:0]  a_req, a_gnt, a_tx_we, a_rx_re, a_rx_vld, a_ep_tx_wmsk;
  logic [15:0] a_tx_addr, a_rx_data, a_ep_tx_data, a_ep_rx_d1;
  logic [31:0] a_tx_data;
  logic [3:0]  a_tx_wmsk;
  logic [17:0] a_rx_addr;
  logic [7:0]  a_ep_tx_addr;
  logic [8:0]  a_ep_rx_addr;
  logic        a_ep_tx_we, a_ep_rx_re, a_busy;
  logic [2:0]  a_owner;

  logic [3:0]  b_req, b_gnt, b_tx_we, b_rx_re, b_rx_vld;
  logic [31:0] b_tx_addr;
  logic [63:0] b_tx_data;
  logic [7:0]  b_tx_wmsk, b_ep_tx_addr;
  logic [35:0] b_rx_addr;
  logic [15:0] b_rx_data, b_ep_tx_data, b_ep_rx_d1;
  logic [1:0]  b_ep_tx_wmsk;
  logic [8:0]  b_ep_rx_addr;
  logic        b_ep_tx_we, b_ep_rx_re, b_busy;
  logic [2:0]  b_owner;

  ep_buf_arb #(.N_CH(2), .TX_AW(8), .RX_AW(9), .DW(16), .MAX_HOLD(4)) dut_a (
    .clk(clk), .rst(rst), .ch_req(a_req), .ch_gnt(a_gnt),
    .ch_tx_addr(a_tx_addr), .ch_tx_data(a_tx_data), .ch_tx_wmsk(a_tx_wmsk), .ch_tx_we(a_tx_we),
    .ch_rx_addr(a_rx_addr), .ch_rx_re(a_rx_re), .ch_rx_data(a_rx_data), .ch_rx_vld(a_rx_vld),
    .ep_tx_addr_0(a_ep_tx_addr), .ep_tx_data_0(a_ep_tx_data), .ep_tx_wmsk_0(a_ep_tx_wmsk),
    .ep_tx_we_0(a_ep_tx_we), .ep_rx_addr_0(a_ep_rx_addr), .ep_rx_re_0(a_ep_rx_re),
    .ep_rx_data_1(a_ep_rx_d1), .owner(a_owner), .busy(a_busy));

  ep_buf_arb #(.N_CH(4), .TX_AW(8), .RX_AW(9), .DW(16), .MAX_HOLD(0)) dut_b (
    .clk(clk), .rst(rst), .ch_req(b_req), .ch_gnt(b_gnt),
    .ch_tx_addr(b_tx_addr), .ch_tx_data(b_tx_data), .ch_tx_wmsk(b_tx_wmsk), .ch_tx_we(b_tx_we),
    .ch_rx_addr(b_rx_addr), .ch_rx_re(b_rx_re), .ch_rx_data(b_rx_data), .ch_rx_vld(b_rx_vld),
    .ep_tx_addr_0(b_ep_tx_addr), .ep_tx_data_0(b_ep_tx_data), .ep_tx_wmsk_0(b_ep_tx_wmsk),
    .ep_tx_we_0(b_ep_tx_we), .ep_rx_addr_0(b_ep_rx_addr), .ep_rx_re_0(b_ep_rx_re),
    .ep_rx_data_1(b_ep_rx_d1), .owner(b_owner), .busy(b_busy));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Buffer read model: one-cycle latency, 0x1FF holds 0xA5A5.
  always @(posedge clk) begin
    if (a_ep_rx_re) a_ep_rx_d1 <= (a_ep_rx_addr == 9'h1FF) ? 16'hA5A5 : 16'h1234;
    b_ep_rx_d1 <= 16'h0;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    total++; if (a_gnt !== 2'b00) begin bad++; $display("FAIL reset_gnt got=%b want=00", a_gnt); end
    total++; if (a_busy !== 1'b0 || a_owner !== 3'd0) begin bad++; $display("FAIL reset_state busy=%b owner=%0d want 0/0", a_busy, a_owner); end
    total++; if (a_ep_tx_we !== 1'b0 || a_ep_tx_addr !== 8'h0) begin bad++; $display("FAIL reset_tx we=%b addr=%h want 0/00", a_ep_tx_we, a_ep_tx_addr); end
    total++; if (a_rx_vld !== 2'b00 || a_ep_rx_re !== 1'b0) begin bad++; $display("FAIL reset_rx vld=%b re=%b want 00/0", a_rx_vld, a_ep_rx_re); end
    total++; if (b_gnt !== 4'h0 || b_busy !== 1'b0) begin bad++; $display("FAIL reset_b gnt=%b busy=%b want 0000/0", b_gnt, b_busy); end
  endtask

  task automatic test_round_robin();
    int ord[5] = '{0, 1, 2, 3, 0};
    logic [3:0] exp;
    b_req = 4'hF;
    for (int n = 0; n < 5; n++)
      for (int j = 0; j < 3; j++) begin
        tick();
        exp = 4'b0001 << ord[n];
        total++;
        if (b_gnt !== exp) begin bad++; $display("FAIL rr_gnt step=%0d.%0d got=%b want=%b", n, j, b_gnt, exp); end
        b_req = 4'hF;
        if (j == 2) b_req[ord[n]] = 1'b0;
      end
    b_req = 4'h0;
    tick();
    total++; if (b_busy !== 1'b0 || b_gnt !== 4'h0) begin bad++; $display("FAIL rr_idle busy=%b gnt=%b want 0/0000", b_busy, b_gnt); end
  endtask

  task automatic test_single_write();
    a_req = 2'b10; a_tx_we = 2'b10;
    a_tx_addr = {8'h12, 8'h00}; a_tx_data = {16'hBEEF, 16'h0000}; a_tx_wmsk = 4'b0000;
    tick();
    total++; if (a_gnt !== 2'b10 || a_owner !== 3'd1) begin bad++; $display("FAIL single_gnt gnt=%b owner=%0d want 10/1", a_gnt, a_owner); end
    total++; if (a_ep_tx_we !== 1'b0) begin bad++; $display("FAIL single_ungranted_we got=%b want=0", a_ep_tx_we); end
    tick();
    total++; if (a_ep_tx_we !== 1'b1 || a_ep_tx_addr !== 8'h12) begin bad++; $display("FAIL single_we we=%b addr=%h want 1/12", a_ep_tx_we, a_ep_tx_addr); end
    total++; if (a_ep_tx_data !== 16'hBEEF || a_ep_tx_wmsk !== 2'b00) begin bad++; $display("FAIL single_data data=%h wmsk=%b want beef/00", a_ep_tx_data, a_ep_tx_wmsk); end
    a_tx_we = 2'b00; a_req = 2'b00;
    tick();
    total++; if (a_ep_tx_we !== 1'b0 || a_busy !== 1'b0) begin bad++; $display("FAIL single_end we=%b busy=%b want 0/0", a_ep_tx_we, a_busy); end
  endtask

  task automatic test_nonowner_strobe();
    a_req = 2'b01;
    tick();
    total++; if (a_gnt !== 2'b01) begin bad++; $display("FAIL nonown_gnt got=%b want=01", a_gnt); end
    a_tx_we = 2'b10; a_rx_re = 2'b10;
    a_rx_addr = {9'h055, 9'h0AA}; a_tx_addr = {8'h34, 8'h56};
    #1;
    total++; if (a_ep_rx_re !== 1'b0 || a_ep_rx_addr !== 9'h0AA) begin bad++; $display("FAIL nonown_rx re=%b addr=%h want 0/0aa", a_ep_rx_re, a_ep_rx_addr); end
    tick();
    total++; if (a_ep_tx_we !== 1'b0 || a_ep_tx_addr !== 8'h56) begin bad++; $display("FAIL nonown_tx we=%b addr=%h want 0/56", a_ep_tx_we, a_ep_tx_addr); end
    total++; if (a_rx_vld !== 2'b00) begin bad++; $display("FAIL nonown_vld got=%b want=00", a_rx_vld); end
    a_tx_we = 2'b00; a_rx_re = 2'b00;
  endtask

  task automatic test_read_handoff();
    a_req = 2'b10; a_rx_re = 2'b01; a_rx_addr = {9'h000, 9'h1FF};
    #1;
    total++; if (a_ep_rx_re !== 1'b1 || a_ep_rx_addr !== 9'h1FF) begin bad++; $display("FAIL handoff_re re=%b addr=%h want 1/1ff", a_ep_rx_re, a_ep_rx_addr); end
    tick();
    a_rx_re = 2'b00;
    total++; if (a_gnt !== 2'b10) begin bad++; $display("FAIL handoff_gnt got=%b want=10", a_gnt); end
    total++; if (a_rx_vld !== 2'b01 || a_rx_data !== 16'hA5A5) begin bad++; $display("FAIL handoff_data vld=%b data=%h want 01/a5a5", a_rx_vld, a_rx_data); end
    a_req = 2'b00;
    tick();
    total++; if (a_rx_vld !== 2'b00 || a_busy !== 1'b0) begin bad++; $display("FAIL handoff_end vld=%b busy=%b want 00/0", a_rx_vld, a_busy); end
  endtask

  task automatic test_preempt();
    logic [1:0] exp;
    a_req = 2'b01;
    for (int k = 0; k < 3; k++) begin
      tick();
      total++; if (a_gnt !== 2'b01) begin bad++; $display("FAIL preempt_solo k=%0d got=%b want=01", k, a_gnt); end
    end
    a_req = 2'b11;
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp = (k < 4) ? 2'b01 : (k < 8) ? 2'b10 : 2'b01;
      total++; if (a_gnt !== exp) begin bad++; $display("FAIL preempt_gnt k=%0d got=%b want=%b", k, a_gnt, exp); end
    end
    a_req = 2'b00;
    tick();
  endtask

  task automatic test_reset_mid();
    a_req = 2'b01; a_tx_we = 2'b01; a_tx_addr = {8'h00, 8'h77};
    tick();
    a_rx_re = 2'b01;
    tick();
    total++; if (a_ep_tx_we !== 1'b1 || a_rx_vld !== 2'b01) begin bad++; $display("FAIL midrst_pending we=%b vld=%b want 1/01", a_ep_tx_we, a_rx_vld); end
    #2; rst = 1'b0; #1;
    total++; if (a_gnt !== 2'b00 || a_busy !== 1'b0 || a_owner !== 3'd0) begin bad++; $display("FAIL midrst_arb gnt=%b busy=%b owner=%0d want 00/0/0", a_gnt, a_busy, a_owner); end
    total++; if (a_ep_tx_we !== 1'b0 || a_ep_tx_addr !== 8'h0) begin bad++; $display("FAIL midrst_tx we=%b addr=%h want 0/00", a_ep_tx_we, a_ep_tx_addr); end
    total++; if (a_rx_vld !== 2'b00 || a_ep_rx_re !== 1'b0) begin bad++; $display("FAIL midrst_rx vld=%b re=%b want 00/0", a_rx_vld, a_ep_rx_re); end
    a_req = 2'b11; a_tx_we = 2'b00; a_rx_re = 2'b00;
    #2; rst = 1'b1;
    tick();
    total++; if (a_gnt !== 2'b01 || a_owner !== 3'd0) begin bad++; $display("FAIL midrst_prio gnt=%b owner=%0d want 01/0", a_gnt, a_owner); end
    a_req = 2'b00;
  endtask

  initial begin
    total = 0; bad = 0;
    a_req = '0; a_tx_we = '0; a_rx_re = '0; a_tx_addr = '0; a_tx_data = '0; a_tx_wmsk = '0; a_rx_addr = '0;
    b_req = '0; b_tx_we = '0; b_rx_re = '0; b_tx_addr = '0; b_tx_data = '0; b_tx_wmsk = '0; b_rx_addr = '0;
    rst = 1'b1;
    #1 rst = 1'b0;
    test_reset();
    tick();
    rst = 1'b1;
    test_round_robin();
    test_single_write();
    test_nonowner_strobe();
    test_read_handoff();
    test_preempt();
    test_reset_mid();
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
